decode_window: RTL

//  Byte-window buffer between the prefetch FIFO and decode. Collects variable-length

---
 rtl/decode_window.sv | 124 ++++++++++++
 1 files changed

// File: rtl/decode_window.sv
// decode_window: byte-window buffer between the prefetch FIFO and instruction decode.
// Fetch beats of 1..FETCH_BYTES bytes are appended above the valid bytes of a
// little-endian window. Decode retires leading bytes each cycle, and the window
// shifts down to drop them. Bytes at or above decoder_count always read as zero.
// Optional build macro DECODE_WINDOW_STATS_EN adds the stall_cycles output and its
// counter.
module decode_window #(
   parameter int WINDOW_BYTES = 12,
   parameter int FETCH_BYTES  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      fetch_valid,
   input  logic [8*FETCH_BYTES-1:0]  fetch_data,
   input  logic [3:0]                fetch_len,
   output logic                      fetch_accept,
   input  logic                      dec_consume,
   input  logic [3:0]                dec_consume_len,
   input  logic                      dec_flush,
   output logic [8*WINDOW_BYTES-1:0] decoder,
   output logic [3:0]                decoder_count,
   output logic                      consume_err
`ifdef DECODE_WINDOW_STATS_EN
   ,
   output logic [15:0]               stall_cycles
`endif
);

   localparam int          WW    = 8 * WINDOW_BYTES;
   localparam int          FW    = 8 * FETCH_BYTES;
   localparam logic [4:0]  LIMIT = 5'(WINDOW_BYTES);

   logic [WW-1:0] win_p0;
   logic [3:0]    count_p0;
   logic          err_p0;

   logic          over;
   logic [3:0]    eff_len;
   logic [3:0]    remain;
   logic [4:0]    fill_sum;
   logic [FW-1:0] fetch_masked;
   logic [WW-1:0] fetch_wide;
   logic [WW-1:0] shifted;
   logic [WW-1:0] win_nxt;
   logic [3:0]    count_nxt;

`ifdef DECODE_WINDOW_STATS_EN
   logic [15:0]   stall_p0;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
`endif

   // Clamp the retire length to what is held, then size the space left for a refill.
   // A consume longer than the window contents is an error, and it is recorded.
   always_comb begin
      over     = dec_consume && (dec_consume_len > count_p0);
      eff_len  = 4'd0;
      if (dec_consume)
         eff_len = over ? count_p0 : dec_consume_len;
      remain   = count_p0 - eff_len;
      fill_sum = {1'b0, remain} + {1'b0, fetch_len};
   end

   // A beat is accepted only when it is non-empty, there is no flush, and it fits in the
   // space left after this cycle's consume.
   assign fetch_accept = fetch_valid & ~dec_flush & (fetch_len != 4'd0) & (fill_sum <= LIMIT);

   // Zero every fetch byte beyond fetch_len, so the zero-filled tail stays intact.
   always_comb begin
      fetch_masked = '0;
      for (int i = 0; i < FETCH_BYTES; i++) begin
         if (i < int'(fetch_len))
            fetch_masked[8*i +: 8] = fetch_data[8*i +: 8];
      end
   end

   // Drop the retired bytes, then place the accepted beat directly above the survivors.
   always_comb begin
      fetch_wide = {{(WW-FW){1'b0}}, fetch_masked};
      shifted    = win_p0 >> {eff_len, 3'b000};
      win_nxt    = shifted;
      count_nxt  = remain;
      if (fetch_accept) begin
         win_nxt   = shifted | (fetch_wide << {remain, 3'b000});
         count_nxt = remain + fetch_len;
      end
      if (dec_flush) begin
         win_nxt   = '0;
         count_nxt = 4'd0;
      end
   end

   // Window state register. Flush has priority. The error flag is sticky until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_p0   <= '0;
         count_p0 <= 4'd0;
         err_p0   <= 1'b0;
      end else begin
         win_p0   <= win_nxt;
         count_p0 <= count_nxt;
         err_p0   <= err_p0 | over;
      end
   end

`ifdef DECODE_WINDOW_STATS_EN
   // Count the cycles in which fetch offered a beat that was refused for lack of space.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_p0 <= 16'd0;
      else if (fetch_valid && !fetch_accept && !dec_flush)
         stall_p0 <= sat_inc(stall_p0);
   end

   assign stall_cycles = stall_p0;
`endif

   assign decoder       = win_p0;
   assign decoder_count = count_p0;
   assign consume_err   = err_p0;

endmodule
